hall_speed_meter: RTL and testbench

//  Per-wheel motor speed measurement. Consumes the periodic start/clr window from the 16 ms hull timer.

---
 rtl/hall_speed_meter_if.sv | 24 ++
 rtl/hall_speed_meter.sv | 179 +++++++++++++++++
 tb/tb_hall_speed_meter.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hall_speed_meter_if.sv
// Window/Hall inputs and published speed-sample outputs of one hall_speed_meter.
// The timer/test side uses master; the meter uses slave.
interface hall_speed_meter_if #(
  parameter int CNT_W = 16
);
  logic                    start;
  logic                    clr;
  logic [2:0]              hall;
  logic signed [CNT_W-1:0] speed;
  logic                    speed_valid;
  logic                    dir;
  logic                    hall_err;
  logic                    stall;

  modport master (
    output start, clr, hall,
    input  speed, speed_valid, dir, hall_err, stall
  );

  modport slave (
    input  start, clr, hall,
    output speed, speed_valid, dir, hall_err, stall
  );
endinterface

// File: rtl/hall_speed_meter.sv
// Per-wheel Hall speed meter: synchronise and debounce the Hall code, track rotor position,
// count signed steps inside the start/clr window and publish one sample per clr rising edge.
module hall_speed_meter #(
  parameter int CNT_W     = 16,
  parameter int FILT_LEN  = 4,
  parameter int STALL_WIN = 4
) (
  input logic               clk,
  input logic               rst_n,
  hall_speed_meter_if.slave bus
);
  localparam int FCW = $clog2(FILT_LEN + 1);
  localparam int SCW = $clog2(STALL_WIN + 1);
  localparam logic [FCW-1:0]          FILT_MAX  = FCW'(FILT_LEN);
  localparam logic [SCW-1:0]          STALL_MAX = SCW'(STALL_WIN);
  localparam logic signed [CNT_W-1:0] ACC_MAX   = {1'b0, {(CNT_W-1){1'b1}}};
  localparam logic signed [CNT_W-1:0] ACC_MIN   = {1'b1, {(CNT_W-1){1'b0}}};
  localparam logic signed [CNT_W-1:0] ACC_ZERO  = {CNT_W{1'b0}};
  localparam logic signed [CNT_W-1:0] ACC_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  // Bit 3 flags an illegal code; bits 2:0 give the position in forward order.
  function automatic logic [3:0] decode(input logic [2:0] code);
    case (code)
      3'd1:    decode = 4'd0;
      3'd3:    decode = 4'd1;
      3'd2:    decode = 4'd2;
      3'd6:    decode = 4'd3;
      3'd4:    decode = 4'd4;
      3'd5:    decode = 4'd5;
      default: decode = 4'b1000;
    endcase
  endfunction

  logic [2:0]              sync1_q, sync1_d, sync2_q, sync2_d;
  logic [2:0]              cand_q, cand_d, filt_q, filt_d;
  logic [FCW-1:0]          fcnt_q, fcnt_d;
  logic [2:0]              pos_q, pos_d;
  logic                    pos_valid_q, pos_valid_d;
  logic                    dir_q, dir_d;
  logic                    err_q, err_d;
  logic                    clr_q, clr_d;
  logic signed [CNT_W-1:0] acc_q, acc_d, speed_q, speed_d;
  logic [SCW-1:0]          stall_cnt_q, stall_cnt_d;
  logic                    speed_valid_q, speed_valid_d;
  logic                    hall_err_q, hall_err_d;
  logic                    stall_q, stall_d;

  logic       filt_chg_s, snap_s, count_en_s, up_s, dn_s, ev_err_s;
  logic [3:0] dec_s;
  logic [2:0] pos_inc_s, pos_dec_s;

  // Next-state logic for filter, position tracker, accumulator, snapshot and stall counter.
  always_comb begin
    sync1_d = bus.hall;
    sync2_d = sync1_q;
    cand_d  = cand_q;
    fcnt_d  = fcnt_q;
    if (sync2_q != cand_q) begin
      cand_d = sync2_q;
      fcnt_d = FCW'(1);
    end else if (fcnt_q != FILT_MAX) begin
      fcnt_d = fcnt_q + FCW'(1);
    end else begin
      fcnt_d = fcnt_q;
    end

    filt_chg_s = (fcnt_q == FILT_MAX) && (cand_q != filt_q);
    filt_d     = filt_chg_s ? cand_q : filt_q;
    dec_s      = decode(cand_q);
    pos_inc_s  = (pos_q == 3'd5) ? 3'd0 : pos_q + 3'd1;
    pos_dec_s  = (pos_q == 3'd0) ? 3'd5 : pos_q - 3'd1;

    pos_d       = pos_q;
    pos_valid_d = pos_valid_q;
    dir_d       = dir_q;
    up_s        = 1'b0;
    dn_s        = 1'b0;
    ev_err_s    = 1'b0;
    if (!filt_chg_s) begin
      pos_d = pos_q;
    end else if (dec_s[3]) begin
      ev_err_s    = 1'b1;
      pos_valid_d = 1'b0;
    end else if (!pos_valid_q) begin
      pos_d       = dec_s[2:0];
      pos_valid_d = 1'b1;
    end else begin
      pos_d = dec_s[2:0];
      if (dec_s[2:0] == pos_inc_s) begin
        up_s  = 1'b1;
        dir_d = 1'b1;
      end else if (dec_s[2:0] == pos_dec_s) begin
        dn_s  = 1'b1;
        dir_d = 1'b0;
      end else begin
        ev_err_s = 1'b1;
      end
    end

    // A delta landing on the snap cycle is dropped because clr is high.
    snap_s     = bus.clr & ~clr_q;
    count_en_s = bus.start & ~bus.clr;
    clr_d      = bus.clr;
    if (snap_s) begin
      acc_d = ACC_ZERO;
    end else if (count_en_s && up_s && (acc_q != ACC_MAX)) begin
      acc_d = acc_q + ACC_ONE;
    end else if (count_en_s && dn_s && (acc_q != ACC_MIN)) begin
      acc_d = acc_q - ACC_ONE;
    end else begin
      acc_d = acc_q;
    end
    err_d = snap_s ? ev_err_s : (err_q | ev_err_s);

    speed_valid_d = snap_s;
    if (!snap_s) begin
      stall_cnt_d = stall_cnt_q;
      speed_d     = speed_q;
      hall_err_d  = hall_err_q;
      stall_d     = stall_q;
    end else begin
      if (acc_q != ACC_ZERO) begin
        stall_cnt_d = {SCW{1'b0}};
      end else if (stall_cnt_q != STALL_MAX) begin
        stall_cnt_d = stall_cnt_q + SCW'(1);
      end else begin
        stall_cnt_d = stall_cnt_q;
      end
      speed_d    = acc_q;
      hall_err_d = err_q;
      stall_d    = (stall_cnt_d == STALL_MAX);
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q       <= 3'd0;
      sync2_q       <= 3'd0;
      cand_q        <= 3'd0;
      filt_q        <= 3'd0;
      fcnt_q        <= {FCW{1'b0}};
      pos_q         <= 3'd0;
      pos_valid_q   <= 1'b0;
      dir_q         <= 1'b0;
      err_q         <= 1'b0;
      clr_q         <= 1'b0;
      acc_q         <= ACC_ZERO;
      speed_q       <= ACC_ZERO;
      stall_cnt_q   <= {SCW{1'b0}};
      speed_valid_q <= 1'b0;
      hall_err_q    <= 1'b0;
      stall_q       <= 1'b0;
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      cand_q        <= cand_d;
      filt_q        <= filt_d;
      fcnt_q        <= fcnt_d;
      pos_q         <= pos_d;
      pos_valid_q   <= pos_valid_d;
      dir_q         <= dir_d;
      err_q         <= err_d;
      clr_q         <= clr_d;
      acc_q         <= acc_d;
      speed_q       <= speed_d;
      stall_cnt_q   <= stall_cnt_d;
      speed_valid_q <= speed_valid_d;
      hall_err_q    <= hall_err_d;
      stall_q       <= stall_d;
    end
  end

  assign bus.speed       = speed_q;
  assign bus.speed_valid = speed_valid_q;
  assign bus.dir         = dir_q;
  assign bus.hall_err    = hall_err_q;
  assign bus.stall       = stall_q;
endmodule

// File: tb/tb_hall_speed_meter.sv
// Bench for hall_speed_meter: two instances (16-bit and 4-bit accumulator) share one stimulus;
// a window-level model is compared every cycle, and each window end is pinned to literals.
module tb_hall_speed_meter;
  localparam int FILT_LEN  = 4;
  localparam int STALL_WIN = 4;
  localparam int HOLD      = FILT_LEN + 4;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       clr   = 1'b0;
  logic [2:0] hall  = 3'd1;

  int checks = 0;
  int passes = 0;
  int pulses = 0;
  int tpos   = 0;

  always #10 clk = ~clk;

  hall_speed_meter_if #(.CNT_W(16)) if16 ();
  hall_speed_meter_if #(.CNT_W(4))  if4 ();
  assign if16.start = start;
  assign if16.clr   = clr;
  assign if16.hall  = hall;
  assign if4.start  = start;
  assign if4.clr    = clr;
  assign if4.hall   = hall;

  hall_speed_meter #(.CNT_W(16), .FILT_LEN(FILT_LEN), .STALL_WIN(STALL_WIN)) dut16 (
    .clk(clk), .rst_n(rst_n), .bus(if16));
  hall_speed_meter #(.CNT_W(4), .FILT_LEN(FILT_LEN), .STALL_WIN(STALL_WIN)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(if4));

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  int h [1:FILT_LEN+2];
  int m_filt, m_pos, m_acc[2], m_speed[2], m_scnt[2];
  bit m_pv, m_err, m_clr_prev, m_dir, m_valid, m_herr, m_stall[2];

  function automatic int pos_of(input int c);
    case (c)
      1: return 0;
      3: return 1;
      2: return 2;
      6: return 3;
      4: return 4;
      5: return 5;
      default: return -1;
    endcase
  endfunction

  function automatic int clamp(input int w, input int v);
    int hi, lo;
    hi = (w == 0) ? 32767 : 7;
    lo = (w == 0) ? -32768 : -8;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  task automatic model_reset();
    for (int j = 1; j <= FILT_LEN + 2; j++) h[j] = 0;
    m_filt = 0; m_pos = 0; m_pv = 0; m_err = 0; m_clr_prev = 0;
    m_dir = 0; m_valid = 0; m_herr = 0;
    for (int w = 0; w < 2; w++) begin
      m_acc[w] = 0; m_speed[w] = 0; m_scnt[w] = 0; m_stall[w] = 0;
    end
  endtask

  // A synchronised code is accepted once it has been seen for FILT_LEN consecutive samples,
  // taken 2 cycles earlier for the synchroniser.
  task automatic model_tick();
    int  cand, p, d, delta;
    bit  all_eq, ev_err, snap;
    cand   = h[FILT_LEN+2];
    all_eq = 1'b1;
    for (int j = 3; j <= FILT_LEN + 2; j++) if (h[j] != cand) all_eq = 1'b0;
    delta  = 0;
    ev_err = 1'b0;
    if (all_eq && cand != m_filt) begin
      m_filt = cand;
      p = pos_of(cand);
      if (p < 0) begin
        ev_err = 1'b1; m_pv = 1'b0;
      end else if (!m_pv) begin
        m_pos = p; m_pv = 1'b1;
      end else begin
        d = (p - m_pos + 6) % 6;
        if (d == 1) begin delta = 1; m_dir = 1'b1; end
        else if (d == 5) begin delta = -1; m_dir = 1'b0; end
        else ev_err = 1'b1;
        m_pos = p;
      end
    end
    snap       = clr && !m_clr_prev;
    m_clr_prev = clr;
    m_valid    = snap;
    if (snap) begin
      m_herr = m_err;
      m_err  = ev_err;
      for (int w = 0; w < 2; w++) begin
        m_speed[w] = m_acc[w];
        if (m_acc[w] != 0) m_scnt[w] = 0;
        else if (m_scnt[w] < STALL_WIN) m_scnt[w] = m_scnt[w] + 1;
        m_stall[w] = (m_scnt[w] == STALL_WIN);
        m_acc[w]   = 0;
      end
    end else begin
      m_err = m_err | ev_err;
      if (start && !clr)
        for (int w = 0; w < 2; w++) m_acc[w] = clamp(w, m_acc[w] + delta);
    end
    for (int j = FILT_LEN + 2; j > 1; j--) h[j] = h[j-1];
    h[1] = int'(hall);
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else model_tick();
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (if16.speed_valid) pulses++;
    chk("cyc.speed16", int'(if16.speed), m_speed[0]);
    chk("cyc.speed4", int'(if4.speed), m_speed[1]);
    chk("cyc.valid", int'(if16.speed_valid), int'(m_valid));
    chk("cyc.valid4", int'(if4.speed_valid), int'(m_valid));
    chk("cyc.dir", int'(if16.dir), int'(m_dir));
    chk("cyc.hall_err", int'(if16.hall_err), int'(m_herr));
    chk("cyc.stall16", int'(if16.stall), int'(m_stall[0]));
    chk("cyc.stall4", int'(if4.stall), int'(m_stall[1]));
  end

  // ---------------- directed stimulus ----------------
  function automatic logic [2:0] code_at(input int p);
    logic [2:0] tbl [6];
    tbl = '{3'd1, 3'd3, 3'd2, 3'd6, 3'd4, 3'd5};
    return tbl[((p % 6) + 6) % 6];
  endfunction

  task automatic step(input logic [2:0] c, input int n);
    hall = c;
    repeat (n) @(negedge clk);
  endtask

  task automatic fwd(input int n);
    for (int i = 0; i < n; i++) begin
      tpos = (tpos + 1) % 6;
      step(code_at(tpos), HOLD);
    end
  endtask

  task automatic rev(input int n);
    for (int i = 0; i < n; i++) begin
      tpos = (tpos + 5) % 6;
      step(code_at(tpos), HOLD);
    end
  endtask

  task automatic end_window(input int clr_len, input int e16, input int e4, input int eerr,
                            input int estall, input string name);
    int p0;
    p0  = pulses;
    clr = 1'b1;
    repeat (clr_len) @(negedge clk);
    clr = 1'b0;
    repeat (4) @(negedge clk);
    chk({name, ".pulses"}, pulses - p0, 1);
    chk({name, ".speed16"}, int'(if16.speed), e16);
    chk({name, ".speed4"}, int'(if4.speed), e4);
    chk({name, ".hall_err"}, int'(if16.hall_err), eerr);
    chk({name, ".stall"}, int'(if16.stall), estall);
  endtask

  task automatic chk_zero(input string name);
    chk({name, ".speed16"}, int'(if16.speed), 0);
    chk({name, ".speed4"}, int'(if4.speed), 0);
    chk({name, ".valid"}, int'(if16.speed_valid), 0);
    chk({name, ".dir"}, int'(if16.dir), 0);
    chk({name, ".hall_err"}, int'(if16.hall_err), 0);
    chk({name, ".stall"}, int'(if16.stall), 0);
  endtask

  initial begin
    int p0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    start = 1'b1;

    // Forward 10 steps; the 4-bit instance saturates at +7.
    fwd(10);
    end_window(1, 10, 7, 0, 0, "fwd10");
    chk("fwd10.dir", int'(if16.dir), 1);
    chk("fwd10.raw16", int'(unsigned'(if16.speed)), 10);

    // Reverse 7 steps.
    rev(7);
    end_window(1, -7, -7, 0, 0, "rev7");
    chk("rev7.dir", int'(if16.dir), 0);
    chk("rev7.raw16", int'(unsigned'(if16.speed)), 32'h0000_FFF9);

    // Short glitches on hall[0] are filtered out.
    for (int i = 0; i < 3; i++) begin
      step(code_at(tpos) ^ 3'd1, 2);
      step(code_at(tpos), 6);
    end
    end_window(1, 0, 0, 0, 0, "glitch");

    // Illegal code 7, then re-sync (not counted), then one counted step.
    step(3'd7, 10);
    tpos = (tpos + 1) % 6;
    step(code_at(tpos), HOLD);
    fwd(1);
    end_window(1, 1, 1, 1, 0, "illegal");

    // One good step, then a +2 jump; the following clean window clears hall_err.
    fwd(1);
    tpos = (tpos + 2) % 6;
    step(code_at(tpos), HOLD);
    end_window(1, 1, 1, 1, 0, "jump");
    fwd(1);
    end_window(1, 1, 1, 0, 0, "clean");

    // clr held 5 cycles yields one snapshot.
    rev(2);
    end_window(5, -2, -2, 0, 0, "clrhold");

    // A step timed to land on the snap edge is counted in neither window.
    rev(1);
    tpos = (tpos + 5) % 6;
    hall = code_at(tpos);
    repeat (FILT_LEN + 2) @(negedge clk);
    end_window(1, -1, -1, 0, 0, "snapedge.a");
    repeat (HOLD) @(negedge clk);
    end_window(1, 0, 0, 0, 0, "snapedge.b");

    // Saturation of the 4-bit instance.
    fwd(9);
    end_window(1, 9, 7, 0, 0, "sat");

    // Stall: first window has steps with start low (dropped, dir still tracks, no snapshot).
    start = 1'b0;
    p0 = pulses;
    rev(3);
    repeat (30) @(negedge clk);
    chk("nostart.pulses", pulses - p0, 0);
    chk("nostart.dir", int'(if16.dir), 0);
    end_window(1, 0, 0, 0, 0, "stall1");
    start = 1'b1;
    repeat (HOLD) @(negedge clk);
    end_window(1, 0, 0, 0, 0, "stall2");
    repeat (HOLD) @(negedge clk);
    end_window(1, 0, 0, 0, 0, "stall3");
    repeat (HOLD) @(negedge clk);
    end_window(1, 0, 0, 0, 1, "stall4");
    fwd(1);
    end_window(1, 1, 1, 0, 0, "unstall");

    // Asynchronous reset mid-window discards the partial count.
    fwd(2);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("midreset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    fwd(2);
    end_window(1, 2, 2, 0, 0, "postreset");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
